// File: rtl/risc_v_pkg.sv
// Shared encodings for the multi-cycle RISC-V core:
// opcodes, ALU ops, mux selects, FSM states and the control word.
package risc_v_pkg;

    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_LD = 7'b0000011;
    localparam logic [6:0] OP_ST = 7'b0100011;
    localparam logic [6:0] OP_U  = 7'b0110111;
    localparam logic [6:0] OP_B  = 7'b1100011;

    typedef enum logic [2:0] {
        ALU_R   = 3'b000,
        ALU_I   = 3'b001,
        ALU_ADD = 3'b010,
        ALU_U   = 3'b100,
        ALU_BR  = 3'b101
    } alu_op_e;

    typedef enum logic [1:0] {
        SRC_A_PC    = 2'b00,
        SRC_A_RS1   = 2'b01,
        SRC_A_OLDPC = 2'b10
    } src_a_e;

    typedef enum logic [1:0] {
        SRC_B_RS2  = 2'b00,
        SRC_B_FOUR = 2'b01,
        SRC_B_IMM  = 2'b10
    } src_b_e;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC_R,
        S_EXEC_I,
        S_EXEC_U,
        S_ADDR,
        S_MEM_RD,
        S_MEM_WR,
        S_MEM_WB,
        S_ALU_WB,
        S_BRANCH
    } state_e;

    typedef struct packed {
        logic    pc_write;
        logic    pc_src;
        logic    iord;
        logic    ir_write;
        logic    mem_read;
        logic    mem_write;
        logic    mem_to_reg;
        logic    reg_write;
        src_a_e  alu_src_a;
        src_b_e  alu_src_b;
        alu_op_e alu_op;
        logic    branch;
        logic    instr_done;
        logic    illegal;
    } ctrl_t;

    // Unsupported opcodes map back to FETCH
    function automatic state_e decode_target(input logic [6:0] op);
        state_e s;
        case (op)
            OP_R:        s = S_EXEC_R;
            OP_I:        s = S_EXEC_I;
            OP_U:        s = S_EXEC_U;
            OP_LD, OP_ST: s = S_ADDR;
            OP_B:        s = S_BRANCH;
            default:     s = S_FETCH;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/multi_cycle_control_if.sv
// Controller <-> datapath/memory bundle for the multi-cycle core.
interface multi_cycle_control_if;

    logic [6:0] OP_i;
    logic       Mem_Ready_i;
    logic       Zero_i;
    logic       PC_Write_o;
    logic       PC_Src_o;
    logic       IorD_o;
    logic       IR_Write_o;
    logic       Mem_Read_o;
    logic       Mem_Write_o;
    logic       Mem_to_Reg_o;
    logic       Reg_Write_o;
    logic [1:0] ALU_Src_A_o;
    logic [1:0] ALU_Src_B_o;
    logic [2:0] ALU_Op_o;
    logic       Branch_o;
    logic       Instr_Done_o;
    logic       Illegal_o;

    modport master (
        input  OP_i, Mem_Ready_i, Zero_i,
        output PC_Write_o, PC_Src_o, IorD_o, IR_Write_o,
        output Mem_Read_o, Mem_Write_o, Mem_to_Reg_o, Reg_Write_o,
        output ALU_Src_A_o, ALU_Src_B_o, ALU_Op_o,
        output Branch_o, Instr_Done_o, Illegal_o
    );

    modport slave (
        output OP_i, Mem_Ready_i, Zero_i,
        input  PC_Write_o, PC_Src_o, IorD_o, IR_Write_o,
        input  Mem_Read_o, Mem_Write_o, Mem_to_Reg_o, Reg_Write_o,
        input  ALU_Src_A_o, ALU_Src_B_o, ALU_Op_o,
        input  Branch_o, Instr_Done_o, Illegal_o
    );

endinterface

// File: rtl/multi_cycle_output_decode.sv
// Combinational control-word decode for each controller state.
module multi_cycle_output_decode
    import risc_v_pkg::*;
(
    input  state_e     state_i,
    input  logic       mem_ready_i,
    input  logic       zero_i,
    input  logic [6:0] op_i,
    output ctrl_t      ctrl_o
);

    always_comb begin
        ctrl_o = '0;
        unique case (state_i)
            S_FETCH: begin
                ctrl_o.mem_read  = 1'b1;
                ctrl_o.alu_src_b = SRC_B_FOUR;
                ctrl_o.alu_op    = ALU_ADD;
                ctrl_o.ir_write  = mem_ready_i;
                ctrl_o.pc_write  = mem_ready_i;
            end
            S_DECODE: begin
                ctrl_o.alu_src_a = SRC_A_OLDPC;
                ctrl_o.alu_src_b = SRC_B_IMM;
                ctrl_o.alu_op    = ALU_ADD;
                ctrl_o.illegal   = (decode_target(op_i) == S_FETCH);
            end
            S_EXEC_R: begin
                ctrl_o.alu_src_a = SRC_A_RS1;
                ctrl_o.alu_src_b = SRC_B_RS2;
                ctrl_o.alu_op    = ALU_R;
            end
            S_EXEC_I: begin
                ctrl_o.alu_src_a = SRC_A_RS1;
                ctrl_o.alu_src_b = SRC_B_IMM;
                ctrl_o.alu_op    = ALU_I;
            end
            S_EXEC_U: begin
                ctrl_o.alu_src_b = SRC_B_IMM;
                ctrl_o.alu_op    = ALU_U;
            end
            S_ADDR: begin
                ctrl_o.alu_src_a = SRC_A_RS1;
                ctrl_o.alu_src_b = SRC_B_IMM;
                ctrl_o.alu_op    = ALU_ADD;
            end
            S_MEM_RD: begin
                ctrl_o.mem_read = 1'b1;
                ctrl_o.iord     = 1'b1;
            end
            S_MEM_WR: begin
                ctrl_o.mem_write  = 1'b1;
                ctrl_o.iord       = 1'b1;
                ctrl_o.instr_done = mem_ready_i;
            end
            S_MEM_WB: begin
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.mem_to_reg = 1'b1;
                ctrl_o.instr_done = 1'b1;
            end
            S_ALU_WB: begin
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.instr_done = 1'b1;
            end
            S_BRANCH: begin
                ctrl_o.alu_src_a  = SRC_A_RS1;
                ctrl_o.alu_src_b  = SRC_B_RS2;
                ctrl_o.alu_op     = ALU_BR;
                ctrl_o.branch     = 1'b1;
                ctrl_o.pc_src     = 1'b1;
                ctrl_o.pc_write   = zero_i;
                ctrl_o.instr_done = 1'b1;
            end
            default: ctrl_o = '0;
        endcase
    end

endmodule

// File: rtl/multi_cycle_control.sv
// Multi-cycle sequencing FSM: state register, next-state logic
// and reset gating of the decoded control word.
module multi_cycle_control
    import risc_v_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    multi_cycle_control_if.master bus
);

    state_e state_q, state_d;
    ctrl_t  ctrl, ctrl_g;

    always_ff @(posedge clk) begin
        if (!reset) state_q <= S_FETCH;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_FETCH:  if (bus.Mem_Ready_i) state_d = S_DECODE;
            S_DECODE: state_d = decode_target(bus.OP_i);
            S_EXEC_R,
            S_EXEC_I,
            S_EXEC_U: state_d = S_ALU_WB;
            S_ADDR:   state_d = (bus.OP_i == OP_LD) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD: if (bus.Mem_Ready_i) state_d = S_MEM_WB;
            S_MEM_WR: if (bus.Mem_Ready_i) state_d = S_FETCH;
            S_MEM_WB,
            S_ALU_WB,
            S_BRANCH: state_d = S_FETCH;
            default:  state_d = S_FETCH;
        endcase
    end

    multi_cycle_output_decode u_decode (
        .state_i     (state_q),
        .mem_ready_i (bus.Mem_Ready_i),
        .zero_i      (bus.Zero_i),
        .op_i        (bus.OP_i),
        .ctrl_o      (ctrl)
    );

    // Reset silences every strobe immediately, even mid-access
    always_comb begin
        ctrl_g = '0;
        if (reset) ctrl_g = ctrl;
    end

    assign bus.PC_Write_o   = ctrl_g.pc_write;
    assign bus.PC_Src_o     = ctrl_g.pc_src;
    assign bus.IorD_o       = ctrl_g.iord;
    assign bus.IR_Write_o   = ctrl_g.ir_write;
    assign bus.Mem_Read_o   = ctrl_g.mem_read;
    assign bus.Mem_Write_o  = ctrl_g.mem_write;
    assign bus.Mem_to_Reg_o = ctrl_g.mem_to_reg;
    assign bus.Reg_Write_o  = ctrl_g.reg_write;
    assign bus.ALU_Src_A_o  = ctrl_g.alu_src_a;
    assign bus.ALU_Src_B_o  = ctrl_g.alu_src_b;
    assign bus.ALU_Op_o     = ctrl_g.alu_op;
    assign bus.Branch_o     = ctrl_g.branch;
    assign bus.Instr_Done_o = ctrl_g.instr_done;
    assign bus.Illegal_o    = ctrl_g.illegal;

endmodule

// File: doc/multi_cycle_control.md
# multi_cycle_control

Sequencing controller for the multi-cycle RISC-V core: a Moore-style FSM with two handshake-gated outputs. It steps each instruction through fetch, decode, execute, memory and writeback over a single shared instruction/data memory port. It drives every datapath mux, write enable and the ALU operation code. It replaces the one-shot opcode decoder wherever the datapath is time-multiplexed.

## Interface
- Parameters: none. Opcode, ALU_Op and mux-select encodings come from the shared package.
- clk  input  1  core clock; all state changes on rising edge
- reset  input  1  synchronous, active-low; sampled on rising edge of clk
- OP_i  input  7  opcode field from the instruction register; stable from DECODE onward
- Mem_Ready_i  input  1  memory completed the current read/write this cycle
- Zero_i  input  1  ALU zero flag (branch compare result)
- PC_Write_o  output  1  load PC
- PC_Src_o  output  1  PC source: 0 = ALU result, 1 = ALUOut register (branch target)
- IorD_o  output  1  memory address source: 0 = PC, 1 = ALUOut
- IR_Write_o  output  1  load instruction register
- Mem_Read_o / Mem_Write_o  output  1 each  memory strobes
- Mem_to_Reg_o  output  1  writeback source: 1 = memory data register, 0 = ALUOut
- Reg_Write_o  output  1  register file write enable
- ALU_Src_A_o  output  2  00 = PC, 01 = rs1, 10 = OldPC
- ALU_Src_B_o  output  2  00 = rs2, 01 = constant 4, 10 = immediate
- ALU_Op_o  output  3  000 R, 001 I-logic, 010 add, 100 U, 101 branch
- Branch_o  output  1  branch-compare cycle
- Instr_Done_o  output  1  one-cycle pulse on the instruction's final cycle
- Illegal_o  output  1  one-cycle pulse when an unsupported opcode is decoded

## Operation
- States: FETCH, DECODE, EXEC_R, EXEC_I, EXEC_U, ADDR, MEM_RD, MEM_WR, MEM_WB, ALU_WB, BRANCH.
- FETCH
  - Mem_Read=1, IorD=0, A=00, B=01, ALU_Op=010.
  - IR_Write and PC_Write equal Mem_Ready_i (Mealy).
  - Stays in FETCH while Mem_Ready_i=0; goes to DECODE when it is 1.
- DECODE
  - A=10, B=10, ALU_Op=010 (branch target precomputed into ALUOut).
  - Next state by OP_i: 0110011→EXEC_R; 0010011→EXEC_I; 0110111→EXEC_U; 0000011 or 0100011→ADDR; 1100011→BRANCH.
  - Any other opcode: FETCH, with Illegal_o=1 in DECODE.
- EXEC_R: A=01, B=00, op 000 → ALU_WB.
- EXEC_I: A=01, B=10, op 001 → ALU_WB.
- EXEC_U: B=10, op 100 → ALU_WB.
- ADDR: A=01, B=10, op 010 → MEM_RD if OP_i=0000011, else MEM_WR.
- MEM_RD: Mem_Read=1, IorD=1; waits on Mem_Ready_i → MEM_WB.
- MEM_WR: Mem_Write=1, IorD=1; waits on Mem_Ready_i → FETCH. Instr_Done=Mem_Ready_i.
- MEM_WB: Reg_Write=1, Mem_to_Reg=1, Instr_Done=1 → FETCH.
- ALU_WB: Reg_Write=1, Mem_to_Reg=0, Instr_Done=1 → FETCH.
- BRANCH
  - A=01, B=00, op 101, Branch=1, PC_Src=1.
  - PC_Write=Zero_i; Instr_Done=1 → FETCH.
- Any output not listed for a state is 0.

## Timing
- Reset
  - While reset=0, every output is forced to 0 combinationally.
  - At the first rising edge with reset=0, state←FETCH.
  - Reset asserted in any state, including mid memory wait, abandons the instruction. No pulses or strobes are issued.
- Memory handshake
  - A strobe is held constant until the cycle in which Mem_Ready_i=1. That cycle completes the access.
  - Mem_Ready_i is ignored outside FETCH, MEM_RD and MEM_WR.
- Zero-wait latency (Mem_Ready_i=1 on the first strobe cycle):
  - R/I/U: 4 cycles
  - load: 5 cycles
  - store: 4 cycles
  - branch: 3 cycles
  - illegal opcode: 2 cycles
- Each wait cycle adds exactly 1 cycle.
- Exactly one PC_Write per sequential instruction, in FETCH. Branch may add a second PC_Write in BRANCH.
- Instr_Done_o and Illegal_o are never both 1. Each pulse lasts exactly one cycle.

## Structure
- Shared package risc_v_pkg holds:
  - opcode constants (R, I-logic, I-memory, S, U, B)
  - ALU_Op codes
  - ALU_Src_A/B select encodings
  - FSM state encoding
- Sub-module multi_cycle_output_decode is combinational: state, Mem_Ready_i, Zero_i, OP_i → control word.
- Top level keeps the state register, next-state logic and the reset gating.

## Test plan
- Reset held low 3 cycles, then released → all outputs 0 during reset; first cycle after release shows Mem_Read_o=1, IorD_o=0, ALU_Src_B_o=01.
- OP_i=0110011, Mem_Ready_i always 1 → states FETCH, DECODE, EXEC_R, ALU_WB; Reg_Write_o=1 and Instr_Done_o=1 on cycle 4 only; PC_Write_o only on cycle 1.
- Load (0000011), Mem_Ready_i low 2 cycles in both FETCH and MEM_RD → 9 cycles total; Mem_Read_o steady through the waits; Mem_to_Reg_o=1 with Reg_Write_o on the final cycle.
- Store (0100011) → Mem_Write_o=1 and IorD_o=1 in cycle 4; Reg_Write_o never 1.
- Branch (1100011):
  - Zero_i=1 → cycle 3 has PC_Write_o=1, PC_Src_o=1.
  - Zero_i=0 → PC_Write_o=0 in cycle 3.
- OP_i=1111111 → Illegal_o pulses in DECODE, back to FETCH at cycle 3. Separately, reset=0 asserted during a MEM_RD wait → next cycle all outputs 0, then FETCH.
